// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit and the ALU-side datapath:
// opcode constants, field widths and FSM state encoding.
package control_unit_pkg;

  localparam int INSTR_W    = 8;
  localparam int REG_ADDR_W = 2;
  localparam int DATA_W     = 8;
  localparam int RETIRED_W  = 8;

  // ir[7:6] major opcode
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_CTL = 2'b11;  // ir[5]=0 JZ, ir[5]=1 HALT

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

endpackage

// File: rtl/control_unit_if.sv
// Instruction-memory, register-file and ALU connections of the control unit.
// master: the control unit; slave: memory/datapath side.
interface control_unit_if
  import control_unit_pkg::*;
#(
  parameter int PC_W = 5
);

  logic [PC_W-1:0]       imem_addr;
  logic [INSTR_W-1:0]    imem_data;
  logic [REG_ADDR_W-1:0] rf_ra1;
  logic [REG_ADDR_W-1:0] rf_ra2;
  logic [REG_ADDR_W-1:0] rf_wa;
  logic                  rf_we;
  logic                  wb_sel;
  logic [DATA_W-1:0]     imm;
  logic [1:0]            alu_op;
  logic                  alu_zero;

  modport master (
    output imem_addr, rf_ra1, rf_ra2, rf_wa, rf_we, wb_sel, imm, alu_op,
    input  imem_data, alu_zero
  );

  modport slave (
    input  imem_addr, rf_ra1, rf_ra2, rf_wa, rf_we, wb_sel, imm, alu_op,
    output imem_data, alu_zero
  );

endinterface

// File: rtl/control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the retired count.
module sat_counter
  import control_unit_pkg::*;
#(
  parameter int W = RETIRED_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise increment until all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetch/decode/execute/writeback sequencing for a
// 4-register, 8-bit-instruction machine (ADD, SUB, LDI, JZ, HALT).
module control_unit
  import control_unit_pkg::*;
#(
  parameter int PC_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  control_unit_if.master       bus,
  output logic                 busy,
  output logic                 halted,
  output logic [RETIRED_W-1:0] retired
);

  state_t                 state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [INSTR_W-1:0]     ir_q, ir_d;
  logic                   z_q, z_d;
  logic                   ret_inc, ret_clr;
  logic [RETIRED_W-1:0]   ret_count;
  logic [1:0]             op;
  logic [PC_W-1:0]        jz_target;

  assign op        = ir_q[7:6];
  assign jz_target = PC_W'(ir_q[4:0]);

  // Next-state, pc/ir/z_flag updates and retire strobes.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    z_d     = z_q;
    ret_inc = 1'b0;
    ret_clr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = bus.imem_data;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (op)
          OP_ADD, OP_SUB: state_d = S_EXECUTE;
          OP_LDI:         state_d = S_WRITEBACK;
          OP_CTL: begin
            ret_inc = 1'b1;
            if (ir_q[5]) begin
              state_d = S_HALT;
            end else begin
              if (z_q) begin
                pc_d = jz_target;
              end
              state_d = S_FETCH;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_EXECUTE: begin
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        if (op != OP_LDI) begin
          z_d = bus.alu_zero;
        end
        ret_inc = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_d    = '0;
          z_d     = 1'b0;
          ret_clr = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pc, ir and z_flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
    end
  end

  sat_counter #(.W(RETIRED_W)) u_retired (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ret_clr),
    .inc   (ret_inc),
    .count (ret_count)
  );

  // Status/strobe outputs are gated by rst_n so a reset arriving mid-
  // instruction (including in WRITEBACK) shows idle outputs immediately.
  assign bus.imem_addr = pc_q;
  assign bus.rf_ra1    = ir_q[3:2];
  assign bus.rf_ra2    = ir_q[1:0];
  assign bus.rf_wa     = ir_q[5:4];
  assign bus.alu_op    = op;
  assign bus.wb_sel    = (op == OP_LDI);
  assign bus.imm       = {4'b0000, ir_q[3:0]};
  assign bus.rf_we     = rst_n && (state_q == S_WRITEBACK);

  assign busy    = rst_n && (state_q inside {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK});
  assign halted  = rst_n && (state_q == S_HALT);
  assign retired = rst_n ? ret_count : '0;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed programs push expected
// register-file writebacks into a queue; a monitor pops and compares them
// whenever rf_we is seen. Program-level status is checked at fixed cycles.
module tb_control_unit;
  import control_unit_pkg::*;

  localparam int PC_W = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       halted;
  logic [7:0] retired;

  control_unit_if #(.PC_W(PC_W)) bus ();

  control_unit #(.PC_W(PC_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .halted  (halted),
    .retired (retired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory and register-file/ALU model on the slave side.
  logic [7:0] mem [32];
  logic [7:0] rf [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] alu_res;

  assign bus.imem_data = mem[bus.imem_addr];
  assign alu_res  = (bus.alu_op == OP_SUB) ? rf[bus.rf_ra1] - rf[bus.rf_ra2]
                                           : rf[bus.rf_ra1] + rf[bus.rf_ra2];
  assign bus.alu_zero = (alu_res == 8'h00);

  always @(posedge clk) begin
    if (bus.rf_we) rf[bus.rf_wa] <= bus.wb_sel ? bus.imm : alu_res;
  end

  typedef struct {
    int         cyc;
    logic [1:0] wa, ra1, ra2, op;
    logic       wb;
    logic [7:0] imm;
  } wb_t;

  wb_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  t0          = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wb(input int n, input logic [1:0] wa, input logic [1:0] ra1,
                         input logic [1:0] ra2, input logic [1:0] op, input logic wb,
                         input logic [7:0] imm);
    wb_t e;
    e.cyc = t0 + n; e.wa = wa; e.ra1 = ra1; e.ra2 = ra2;
    e.op = op; e.wb = wb; e.imm = imm;
    exp_q.push_back(e);
  endtask

  // Drive a one-cycle start; cycle t0+1 is the first FETCH.
  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Advance to the falling edge of cycle t0+n.
  task automatic at_cyc(input int n);
    int target;
    target = t0 + n;
    if (cyc > target) begin
      vectors++;
      miscompares++;
      $display("FAIL schedule: at cycle %0d, required cycle %0d", cyc, target);
    end
    while (cyc < target) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
  endtask

  // Writeback monitor.
  always @(negedge clk) begin
    wb_t e;
    if (bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rf_we: got write to r%0d at cycle %0d, expected none",
                 bus.rf_wa, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("wb_cycle",  cyc,        e.cyc);
        chk("wb_rf_wa",  bus.rf_wa,  e.wa);
        chk("wb_rf_ra1", bus.rf_ra1, e.ra1);
        chk("wb_rf_ra2", bus.rf_ra2, e.ra2);
        chk("wb_alu_op", bus.alu_op, e.op);
        chk("wb_sel",    bus.wb_sel, e.wb);
        chk("wb_imm",    bus.imm,    e.imm);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'hE0;
    rst_n = 1'b0;
    start = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",    busy,          0);
    chk("rst_halted",  halted,        0);
    chk("rst_retired", retired,       0);
    chk("rst_rf_we",   bus.rf_we,     0);
    chk("rst_addr",    bus.imem_addr, 0);
    chk("rst_alu_op",  bus.alu_op,    0);
    chk("rst_wb_sel",  bus.wb_sel,    0);
    chk("rst_imm",     bus.imm,       0);
    rst_n = 1'b1;

    // LDI r1,5; LDI r2,5; SUB r3,r1,r2; JZ 6; ADD r0,r1,r2; JZ 20 (not taken); HALT
    mem[0] = 8'h95; mem[1] = 8'hA5; mem[2] = 8'h76; mem[3] = 8'hC6;
    mem[6] = 8'h06; mem[7] = 8'hD4; mem[8] = 8'hE0;
    pulse_start();
    push_wb(3,  2'd1, 2'd1, 2'd1, 2'b10, 1'b1, 8'h05);
    push_wb(6,  2'd2, 2'd1, 2'd1, 2'b10, 1'b1, 8'h05);
    push_wb(10, 2'd3, 2'd1, 2'd2, 2'b01, 1'b0, 8'h06);
    push_wb(16, 2'd0, 2'd1, 2'd2, 2'b00, 1'b0, 8'h06);
    at_cyc(1);
    chk("p1_fetch_busy", busy, 1);
    chk("p1_fetch_addr", bus.imem_addr, 0);
    at_cyc(13);
    chk("p1_jz_taken_pc", bus.imem_addr, 6);
    at_cyc(14);
    chk("add_dec_ra1", bus.rf_ra1, 1);
    chk("add_dec_ra2", bus.rf_ra2, 2);
    chk("add_dec_op",  bus.alu_op, 0);
    chk("add_dec_wa",  bus.rf_wa,  0);
    chk("add_dec_we",  bus.rf_we,  0);
    at_cyc(15);
    chk("add_exe_ra1", bus.rf_ra1, 1);
    chk("add_exe_ra2", bus.rf_ra2, 2);
    chk("add_exe_op",  bus.alu_op, 0);
    chk("add_exe_we",  bus.rf_we,  0);
    at_cyc(19);
    chk("jz_nt_pc",      bus.imem_addr, 8);
    chk("jz_nt_busy",    busy, 1);
    chk("jz_nt_retired", retired, 6);
    at_cyc(21);
    chk("p1_halted",  halted, 1);
    chk("p1_busy",    busy, 0);
    chk("p1_retired", retired, 7);
    chk("p1_pc",      bus.imem_addr, 9);

    // SUB r1,r1,r1 (z=1); JZ 31; HALT at 31 -> pc wraps to 0; run twice
    mem[0] = 8'h55; mem[1] = 8'hDF; mem[31] = 8'hE0;
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start();
      push_wb(4, 2'd1, 2'd1, 2'd1, 2'b01, 1'b0, 8'h05);
      at_cyc(1);
      chk("restart_retired", retired, 0);
      chk("restart_addr",    bus.imem_addr, 0);
      chk("restart_busy",    busy, 1);
      chk("restart_halted",  halted, 0);
      at_cyc(7);
      chk("fetch_addr31", bus.imem_addr, 31);
      at_cyc(9);
      chk("wrap_pc",      bus.imem_addr, 0);
      chk("wrap_halted",  halted, 1);
      chk("wrap_busy",    busy, 0);
      chk("wrap_retired", retired, 3);
    end

    // start from HALT clears z_flag: JZ 10 must fall through
    mem[0] = 8'hCA; mem[1] = 8'hE0; mem[10] = 8'hE0;
    pulse_start();
    at_cyc(3);
    chk("zclr_start_pc", bus.imem_addr, 1);
    chk("zclr_start_retired", retired, 1);
    at_cyc(5);
    chk("zclr_start_halted", halted, 1);
    chk("zclr_start_pc2", bus.imem_addr, 2);
    chk("zclr_start_retired2", retired, 2);

    // Set z=1, then SUB interrupted by reset in EXECUTE; start in DECODE ignored
    mem[0] = 8'h55; mem[1] = 8'hE0;
    pulse_start();
    push_wb(4, 2'd1, 2'd1, 2'd1, 2'b01, 1'b0, 8'h05);
    at_cyc(7);
    chk("zset_halted", halted, 1);
    mem[0] = 8'h76; mem[1] = 8'hCA;
    pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_ignored_pc",   bus.imem_addr, 1);
    chk("start_ignored_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_exe_busy",  busy, 0);
    chk("rst_exe_rf_we", bus.rf_we, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_busy",    busy, 0);
    chk("post_rst_halted",  halted, 0);
    chk("post_rst_retired", retired, 0);
    chk("post_rst_rf_we",   bus.rf_we, 0);
    chk("post_rst_addr",    bus.imem_addr, 0);
    chk("post_rst_alu_op",  bus.alu_op, 0);
    chk("post_rst_imm",     bus.imm, 0);
    mem[0] = 8'hCA; mem[1] = 8'hE0;
    pulse_start();
    at_cyc(3);
    chk("zclr_rst_pc", bus.imem_addr, 1);
    at_cyc(5);
    chk("zclr_rst_halted", halted, 1);
    chk("zclr_rst_pc2", bus.imem_addr, 2);

    // Reset landing in WRITEBACK of LDI: no rf_we in the reset cycle
    mem[0] = 8'h95;
    pulse_start();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_wb_rf_we", bus.rf_we, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wb_idle_busy",   busy, 0);
    chk("rst_wb_idle_halted", halted, 0);

    // SUB r1,r1,r1 then JZ 1 forever: retired saturates at 8'hFF
    mem[0] = 8'h55; mem[1] = 8'hC1;
    pulse_start();
    push_wb(4, 2'd1, 2'd1, 2'd1, 2'b01, 1'b0, 8'h05);
    at_cyc(5);
    chk("loop_retired_1", retired, 8'h01);
    chk("loop_pc",        bus.imem_addr, 1);
    at_cyc(205);
    chk("loop_retired_101", retired, 8'h65);
    at_cyc(511);
    chk("loop_retired_254", retired, 8'hFE);
    at_cyc(513);
    chk("loop_retired_255", retired, 8'hFF);
    at_cyc(625);
    chk("loop_retired_sat", retired, 8'hFF);
    chk("loop_busy",        busy, 1);

    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pending_wb", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
